// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready in and out.
// Optional MIX_COLUMNS_INV_EN adds an 'inv' port selecting InvMixColumns per operation.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam logic [1:0]  STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  LAST_COL = 2'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [1:0]           col;
  logic [STATE_W-1:0]   work;
  logic [STATE_W-1:0]   work_nx;
`ifdef MIX_COLUMNS_INV_EN
  logic                 inv_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [COL_W-1:0] mix_fwd(input logic [COL_W-1:0] c);
    logic [7:0] a0, a1, a2, a3, x0, x1, x2, x3;
    {a0, a1, a2, a3} = c;
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
            a0 ^ x1 ^ x2 ^ a2 ^ a3,
            a0 ^ a1 ^ x2 ^ x3 ^ a3,
            x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // 9/11/13/14 multiples built from the 2b, 4b, 8b xtime chain
  function automatic logic [COL_W-1:0] mix_inv(input logic [COL_W-1:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] b2, b4, b8;
    logic [COL_W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[COL_W-1-8*i -: 8];
      b2     = xtime(a[i]);
      b4     = xtime(b2);
      b8     = xtime(b4);
      m9[i]  = b8 ^ a[i];
      m11[i] = b8 ^ b2 ^ a[i];
      m13[i] = b8 ^ b4 ^ a[i];
      m14[i] = b8 ^ b4 ^ b2;
    end
    for (int i = 0; i < 4; i++) begin
      r[COL_W-1-8*i -: 8] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction
`endif

  // Transform the columns selected by the counter, leave the rest untouched
  always_comb begin : mix_comb
    logic [1:0]  ci;
    int unsigned lo;
    ci      = col;
    lo      = 0;
    work_nx = work;
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      ci = col + 2'(k);
      lo = COL_W * (32'd3 - 32'(ci));
`ifdef MIX_COLUMNS_INV_EN
      work_nx[lo +: COL_W] = inv_q ? mix_inv(work[lo +: COL_W]) : mix_fwd(work[lo +: COL_W]);
`else
      work_nx[lo +: COL_W] = mix_fwd(work[lo +: COL_W]);
`endif
    end
  end

  // out_state only ever loads a fully transformed state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= 2'd0;
      work      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            work     <= in_state;
            col      <= 2'd0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef MIX_COLUMNS_INV_EN
            inv_q    <= inv;
`endif
          end
        end
        BUSY: begin
          work <= work_nx;
          if (col == LAST_COL) begin
            col       <= 2'd0;
            out_state <= work_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            col <= col + STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (COLS_PER_CYCLE 1, 4, 2) against a GF(2^8) matrix model.
// Define MIX_COLUMNS_INV_EN to also exercise the inverse transform.
module tb_mix_columns_seq;

  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_state [NDUT];
`ifdef MIX_COLUMNS_INV_EN
  logic         inv       [NDUT];
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned CPC = (g == 0) ? 1 : ((g == 1) ? 4 : 2);
    mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .rst       (rst),
`ifdef MIX_COLUMNS_INV_EN
      .inv       (inv[g]),
`endif
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix times each column
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv_m);
    logic [7:0]   k [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv_m) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(k[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One full transaction; early=1 holds out_ready high from the start
  task automatic txn(input int i, input logic [127:0] st, input int bp, input bit early,
                     output logic [127:0] res, output int lat, output int bad);
    int w;
    in_state[i]  = st;
    in_valid[i]  = 1'b1;
    out_ready[i] = early;
    w = 0;
    while (!in_ready[i] && w < 20) begin step(); w++; end
    step();
    in_valid[i] = 1'b0;
    in_state[i] = rand128();
    lat = 0;
    while (!out_valid[i] && lat < 20) begin step(); lat++; end
    res = out_state[i];
    bad = 0;
    if (!early)
      for (int k = 0; k < bp; k++) begin
        step();
        if (!out_valid[i] || out_state[i] !== res || in_ready[i]) bad++;
      end
    out_ready[i] = 1'b1;
    step();
    if (out_valid[i] || !in_ready[i] || out_state[i] !== res) bad++;
    out_ready[i] = 1'b0;
  endtask

  typedef struct {
    logic [127:0] vin;
    logic [127:0] vexp;
    int           bp;
  } vec_t;

  initial begin
    vec_t         tbl [3];
    logic [127:0] res, mid, st;
    int           lat, bad, cnt, acc_idx, cyc;
    logic [127:0] q [$];
    logic [127:0] got [$];
    bit           acc;

    tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0};
    tbl[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 5};
    tbl[2] = '{128'hf20a225c_db135345_2d26314c_d4d4d4d5, 128'h9fdc589d_8e4da1bc_4d7ebdf8_d5d5d7d6, 2};

    for (int i = 0; i < NDUT; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; out_ready[i] = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv[i] = 1'b0;
`endif
    end
    rst = 1'b1;
    step();
    for (int i = 0; i < NDUT; i++) check($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(0));
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("idle_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("idle_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("idle_out_state[%0d]", i), out_state[i], 128'h0);
    end
    step();
    for (int i = 0; i < NDUT; i++) check($sformatf("idle_hold_ready[%0d]", i), 128'(in_ready[i]), 128'(1));

    // Directed vectors with latency and back-pressure checks
    for (int i = 0; i < NDUT; i++)
      for (int v = 0; v < 3; v++) begin
        txn(i, tbl[v].vin, tbl[v].bp, 1'b0, res, lat, bad);
        check($sformatf("vec%0d_out[%0d]", v, i), res, tbl[v].vexp);
        check($sformatf("vec%0d_lat[%0d]", v, i), 128'(lat), 128'(lat_of(i)));
        check($sformatf("vec%0d_hold[%0d]", v, i), 128'(bad), 128'(0));
      end

    // Reset mid-operation, then recover
    for (int i = 0; i < NDUT; i++) begin
      in_state[i] = tbl[0].vin; in_valid[i] = 1'b1;
      step();
      in_valid[i] = 1'b0;
      repeat ((i == 0) ? 2 : ((i == 1) ? 0 : 1)) step();
      rst = 1'b1;
      #1;
      check($sformatf("abort_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("abort_out_state[%0d]", i), out_state[i], 128'h0);
      step();
      rst = 1'b0;
      step();
      check($sformatf("abort_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
      txn(i, tbl[0].vin, 0, 1'b0, res, lat, bad);
      check($sformatf("abort_redo[%0d]", i), res, tbl[0].vexp);
    end

    // Back-to-back input stream, consumer always ready
    for (int i = 0; i < NDUT; i++) begin
      q.delete(); got.delete();
      for (int k = 0; k < 6; k++) q.push_back(rand128());
      acc_idx = 0;
      in_state[i] = q[0]; in_valid[i] = 1'b1; out_ready[i] = 1'b1;
      cyc = 0;
      while (got.size() < 6 && cyc < 200) begin
        acc = in_valid[i] && in_ready[i];
        if (out_valid[i] && out_ready[i]) got.push_back(out_state[i]);
        step();
        cyc++;
        if (acc) begin
          acc_idx++;
          if (acc_idx < 6) in_state[i] = q[acc_idx];
          else in_valid[i] = 1'b0;
        end
      end
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      cnt = got.size();
      check($sformatf("b2b_count[%0d]", i), 128'(cnt), 128'(6));
      check($sformatf("b2b_accepts[%0d]", i), 128'(acc_idx), 128'(6));
      for (int k = 0; k < cnt && k < 6; k++)
        check($sformatf("b2b_out%0d[%0d]", k, i), got[k], ref_mix(q[k], 1'b0));
      step();
    end

    // Random states against the model
    for (int i = 0; i < NDUT; i++)
      for (int k = 0; k < 8; k++) begin
        st = rand128();
        txn(i, st, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res, lat, bad);
        check($sformatf("rand%0d_out[%0d]", k, i), res, ref_mix(st, 1'b0));
        check($sformatf("rand%0d_hold[%0d]", k, i), 128'(bad), 128'(0));
      end

`ifdef MIX_COLUMNS_INV_EN
    for (int i = 0; i < NDUT; i++) begin
      inv[i] = 1'b1;
      txn(i, tbl[0].vexp, 0, 1'b0, res, lat, bad);
      check($sformatf("inv_vec[%0d]", i), res, tbl[0].vin);
      check($sformatf("inv_lat[%0d]", i), 128'(lat), 128'(lat_of(i)));
      for (int k = 0; k < 4; k++) begin
        st = rand128();
        inv[i] = 1'b0;
        txn(i, st, 1, 1'b0, mid, lat, bad);
        check($sformatf("rt_fwd%0d[%0d]", k, i), mid, ref_mix(st, 1'b0));
        inv[i] = 1'b1;
        txn(i, mid, 0, 1'b1, res, lat, bad);
        check($sformatf("rt_inv%0d[%0d]", k, i), res, st);
      end
      inv[i] = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
